// File: rtl/regfile_irst_param.sv
// Parametrised register file with a hidden IRST command register at address 0 and a req/ack/done/timeout
// handshake FSM on it. Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_irst_param #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 3,
    parameter int                NUM_RD       = 2,
    parameter logic [DATA_W-1:0] IRST_INIT    = 16'h8F0F,
    parameter int                IRST_TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [ADDR_W-1:0]        i_wr_addr,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [DATA_W-1:0]        o_irst_cmd,
    output logic                     o_irst_req,
    input  logic                     i_irst_ack,
    input  logic                     i_irst_done,
    output logic                     o_irst_busy,
    output logic                     o_irst_timeout
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(IRST_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IRST_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_BUSY = 2'd2;

    logic [DATA_W-1:0] r_mem [1:DEPTH-1];
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_cmd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_req;
    logic              r_busy;
    logic              r_timeout;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_cmd_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_timeout_nxt;
    logic              w_wr_cmd;

    assign w_wr_cmd = i_wr_en && (i_wr_addr == '0);

    // Architectural registers 1..DEPTH-1; address 0 is routed to the command register instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Handshake next-state: done aborts from any state and beats writes, ack and timeout alike.
    always_comb begin
        w_state_nxt   = r_state;
        w_cmd_nxt     = r_cmd;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        if (i_irst_done) begin
            w_state_nxt = ST_IDLE;
            w_cmd_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_cmd) begin
                        w_cmd_nxt = i_wr_data;
                    end else begin
                        w_cmd_nxt = r_cmd;
                    end
                    if (r_cmd[DATA_W-1]) begin
                        w_state_nxt = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (i_irst_ack) begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt   = ST_IDLE;
                        w_cmd_nxt     = '0;
                        w_timeout_nxt = 1'b1;
                    end else if (r_cnt != CNT_MAX) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, command and registered handshake outputs; reset re-arms the command register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cmd     <= IRST_INIT;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cmd     <= w_cmd_nxt;
            r_cnt     <= w_cnt_nxt;
            r_req     <= (w_state_nxt == ST_REQ);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_irst_cmd     = r_cmd;
    assign o_irst_req     = r_req;
    assign o_irst_busy    = r_busy;
    assign o_irst_timeout = r_timeout;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = i_rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux: address 0 always reads zero and is never forwarded.
        always_comb begin
            if (w_addr == '0) begin
                w_data = '0;
`ifdef REGFILE_BYPASS_EN
            end else if (i_wr_en && (i_wr_addr == w_addr)) begin
                w_data = i_wr_data;
`endif
            end else begin
                w_data = r_mem[w_addr];
            end
        end

        assign o_rd_data[k*DATA_W +: DATA_W] = w_data;
    end

endmodule

// File: tb/tb_regfile_irst_param.sv
// Self-checking bench for regfile_irst_param: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model (honours REGFILE_BYPASS_EN).
module tb_regfile_irst_param;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int NR    = 2;
    localparam int TMO   = 64;
    localparam int DEPTH = 8;

    localparam int M_IDLE     = 0;
    localparam int M_WAIT_ACK = 1;
    localparam int M_RUNNING  = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           wr_en;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [DW-1:0]  irst_cmd;
    logic           irst_req;
    logic           irst_ack;
    logic           irst_done;
    logic           irst_busy;
    logic           irst_timeout;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_cmd;
    int            m_mode;
    int            m_busy_n;
    logic          m_tmo;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_irst_param dut (
        .clk            (clk),
        .rst            (rst),
        .i_wr_en        (wr_en),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_irst_cmd     (irst_cmd),
        .o_irst_req     (irst_req),
        .i_irst_ack     (irst_ack),
        .i_irst_done    (irst_done),
        .o_irst_busy    (irst_busy),
        .o_irst_timeout (irst_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_cmd    = 16'h8F0F;
        m_mode   = M_IDLE;
        m_busy_n = 0;
        m_tmo    = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, from the inputs held across that edge.
    task automatic model_step();
        logic [DW-1:0] new_cmd;
        int            new_mode;
        new_cmd  = m_cmd;
        new_mode = m_mode;
        m_tmo    = 1'b0;
        if (irst_done) begin
            new_cmd  = '0;
            new_mode = M_IDLE;
        end else if (m_mode == M_IDLE) begin
            if (wr_en && wr_addr == 3'd0) new_cmd = wr_data;
            if (m_cmd[DW-1]) new_mode = M_WAIT_ACK;
        end else if (m_mode == M_WAIT_ACK) begin
            if (irst_ack) begin
                new_mode = M_RUNNING;
                m_busy_n = 0;
            end
        end else begin
            m_busy_n++;
            if (m_busy_n == TMO) begin
                new_cmd  = '0;
                new_mode = M_IDLE;
                m_tmo    = 1'b1;
            end
        end
        if (wr_en && wr_addr != 3'd0) m_mem[wr_addr] = wr_data;
        m_cmd  = new_cmd;
        m_mode = new_mode;
    endtask

    function automatic logic [DW-1:0] exp_rd(input int k);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (a == 3'd0) return '0;
        if (BYPASS && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    task automatic compare_all();
        chk("cmd",     32'(irst_cmd),     32'(m_cmd));
        chk("req",     32'(irst_req),     32'(m_mode == M_WAIT_ACK));
        chk("busy",    32'(irst_busy),    32'(m_mode != M_IDLE));
        chk("timeout", 32'(irst_timeout), 32'(m_tmo));
        for (int k = 0; k < NR; k++) begin
            chk("rd_data", 32'(rd_data[k*DW +: DW]), 32'(exp_rd(k)));
        end
    endtask

    // Edge, model update, then full comparison half a cycle later; inputs change after this returns.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic arm_and_enter_busy();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h8001;
        tick();
        wr_en = 1'b0;
        tick();
        irst_ack = 1'b1;
        tick();
        irst_ack = 1'b0;
    endtask

    initial begin
        int seen_at;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        irst_ack = 1'b0; irst_done = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset_cmd", 32'(irst_cmd), 32'h8F0F);
        chk("reset_req", 32'(irst_req), 32'h0);

        // Armed out of reset: REQ on the first edge, ack two cycles later, done ends it.
        rst = 1'b0;
        tick();
        chk("t1_req", 32'(irst_req), 32'h1);
        chk("t1_cmd", 32'(irst_cmd), 32'h8F0F);
        tick();
        irst_ack = 1'b1;
        tick();
        irst_ack = 1'b0;
        chk("t1_busy", 32'(irst_busy), 32'h1);
        chk("t1_req_low", 32'(irst_req), 32'h0);
        repeat (2) tick();
        irst_done = 1'b1;
        tick();
        irst_done = 1'b0;
        chk("t1_cmd_clr", 32'(irst_cmd), 32'h0);
        chk("t1_idle", 32'({irst_req, irst_busy}), 32'h0);

        // Plain register write / read and the zero register.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hBEEF; rd_addr = {3'd5, 3'd5};
        #1 chk("t3_before", 32'(rd_data[15:0]), BYPASS ? 32'hBEEF : 32'h0);
        tick();
        wr_en = 1'b0;
        #1 chk("t3_p0", 32'(rd_data[15:0]), 32'hBEEF);
        chk("t3_p1", 32'(rd_data[31:16]), 32'hBEEF);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h1111; rd_addr = {3'd0, 3'd0};
        #1 chk("t3_r0", 32'(rd_data), 32'h0);
        wr_en = 1'b0;

        // Same-cycle write and read of r3.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr = {3'd0, 3'd3};
        #1 chk("t4_same", 32'(rd_data[15:0]), BYPASS ? 32'h1234 : 32'h0);
        tick();
        wr_en = 1'b0;
        #1 chk("t4_next", 32'(rd_data[15:0]), 32'h1234);

        // Arm by writing address 0, then let the engine time out.
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h8001;
        tick();
        wr_en = 1'b0;
        chk("t2_cmd", 32'(irst_cmd), 32'h8001);
        tick();
        chk("t2_req", 32'(irst_req), 32'h1);
        irst_ack = 1'b1;
        tick();
        irst_ack = 1'b0;
        seen_at = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (irst_timeout) begin
                seen_at = n;
                break;
            end
        end
        chk("t2_tmo_cycles", 32'(seen_at), 32'd64);
        chk("t2_tmo_cmd", 32'(irst_cmd), 32'h0);
        tick();
        chk("t2_tmo_pulse", 32'(irst_timeout), 32'h0);

        // Command locked while busy; done beats a same-cycle command write in IDLE.
        arm_and_enter_busy();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h8055;
        tick();
        wr_en = 1'b0;
        chk("t5_locked", 32'(irst_cmd), 32'h8001);
        irst_done = 1'b1;
        tick();
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'h8123;
        tick();
        wr_en = 1'b0; irst_done = 1'b0;
        chk("t5_done_wins", 32'(irst_cmd), 32'h0);

        // Asynchronous reset in the middle of BUSY.
        arm_and_enter_busy();
        tick();
        rst = 1'b1;
        #1 model_reset();
        chk("t6_busy", 32'(irst_busy), 32'h0);
        chk("t6_req", 32'(irst_req), 32'h0);
        chk("t6_cmd", 32'(irst_cmd), 32'h8F0F);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_rearm", 32'(irst_req), 32'h1);

        // Randomized traffic, including rare resets and every ack/done/write collision.
        for (int c = 0; c < 4000; c++) begin
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                #1 model_reset();
            end
            wr_en     = ($urandom_range(0, 1) == 1);
            wr_addr   = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            wr_data   = 16'($urandom);
            rd_addr   = 6'($urandom);
            irst_ack  = ($urandom_range(0, 2) == 0);
            irst_done = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
